// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the keypad scan decoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StDebPress = 2'd1,
        StHeld     = 2'd2
    } state_e;

    // Width of a key code covering n columns by m rows; never narrower than 1 bit.
    function automatic int unsigned calc_cw(input int unsigned n, input int unsigned m);
        return (n * m > 1) ? $clog2(n * m) : 1;
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Lowest-set-bit priority encoder with an exactly-one-bit-set flag.
module onehot_to_bin #(
    parameter int unsigned W  = 4,
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          onehot
);

    always_comb begin
        idx = '0;
        // Walk downwards so the lowest set bit is the last assignment.
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign onehot = (vec != '0) && ((vec & (vec - W'(1))) == '0);

endmodule

// File: rtl/keypad_scan_decoder.sv
// Scanned-keypad front end: debounces one key at a time, encodes it and hands
// each press to a valid/ready consumer with sticky overflow and strobe-error flags.
module keypad_scan_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned M        = 4,
    parameter int unsigned DEBOUNCE = 3,
    localparam int unsigned CW      = calc_cw(N, M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  col_onehot,
    input  logic [M-1:0]  row_in,
    output logic          key_valid,
    input  logic          key_ready,
    output logic [CW-1:0] key_code,
    output logic          key_down,
    output logic          overflow,
    output logic          col_err,
    input  logic          clear_status
);

    localparam int unsigned CIW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RIW  = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned CNTW = $clog2(DEBOUNCE + 1);

    logic [CIW-1:0] col_idx;
    logic           col_ok;
    logic [RIW-1:0] row_idx;
    logic           row_onehot;
    logic           hit;

    onehot_to_bin #(.W(N)) u_col_enc (
        .vec    (col_onehot),
        .idx    (col_idx),
        .onehot (col_ok)
    );

    onehot_to_bin #(.W(M)) u_row_enc (
        .vec    (row_in),
        .idx    (row_idx),
        .onehot (row_onehot)
    );

    assign hit = |row_in;

    state_e          state_q, state_d;
    logic [CIW-1:0]  cand_col_q, cand_col_d;
    logic [RIW-1:0]  cand_row_q, cand_row_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            key_valid_q, key_valid_d;
    logic [CW-1:0]   key_code_q, key_code_d;
    logic            key_down_q, key_down_d;
    logic            overflow_q, overflow_d;
    logic            col_err_q, col_err_d;
    logic            confirm, accept;
    logic [CIW-1:0]  conf_col;
    logic [RIW-1:0]  conf_row;

    assign accept  = key_valid_q && key_ready;
    assign cnt_inc = (cnt_q == CNTW'(DEBOUNCE)) ? cnt_q : cnt_q + CNTW'(1);

    always_comb begin
        state_d     = state_q;
        cand_col_d  = cand_col_q;
        cand_row_d  = cand_row_q;
        cnt_d       = cnt_q;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        key_down_d  = key_down_q;
        overflow_d  = overflow_q;
        col_err_d   = col_err_q;
        confirm     = 1'b0;
        conf_col    = cand_col_q;
        conf_row    = cand_row_q;

        if (accept) begin
            key_valid_d = 1'b0;
        end
        if (clear_status) begin
            overflow_d = 1'b0;
            col_err_d  = 1'b0;
        end

        if (!col_ok) begin
            col_err_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        cand_col_d = col_idx;
                        cand_row_d = row_idx;
                        cnt_d      = CNTW'(1);
                        if (DEBOUNCE == 1) begin
                            confirm  = 1'b1;
                            conf_col = col_idx;
                            conf_row = row_idx;
                        end else begin
                            state_d = StDebPress;
                        end
                    end
                end
                StDebPress: begin
                    if (col_idx == cand_col_q) begin
                        if (row_in[cand_row_q]) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc >= CNTW'(DEBOUNCE)) begin
                                confirm = 1'b1;
                            end
                        end else begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end
                end
                StHeld: begin
                    if (col_idx == cand_col_q) begin
                        if (!row_in[cand_row_q]) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc >= CNTW'(DEBOUNCE)) begin
                                key_down_d = 1'b0;
                                state_d    = StIdle;
                                cnt_d      = '0;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        // The held state reuses the counter for release debouncing.
        if (confirm) begin
            key_down_d = 1'b1;
            state_d    = StHeld;
            cnt_d      = '0;
            if (!key_valid_q || accept) begin
                key_code_d  = CW'(conf_col) * CW'(M) + CW'(conf_row);
                key_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cand_col_q  <= '0;
            cand_row_q  <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_down_q  <= 1'b0;
            overflow_q  <= 1'b0;
            col_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_col_q  <= cand_col_d;
            cand_row_q  <= cand_row_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_down_q  <= key_down_d;
            overflow_q  <= overflow_d;
            col_err_q   <= col_err_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_down  = key_down_q;
    assign overflow  = overflow_q;
    assign col_err   = col_err_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Directed bench for keypad_scan_decoder with N=M=4, DEBOUNCE=3.
module tb_keypad_scan_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col_onehot = 4'b0001;
    logic [3:0] row_in = 4'b0000;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic [3:0] key_code;
    logic       key_down;
    logic       overflow;
    logic       col_err;
    logic       clear_status = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [3:0] ring = 4'b0001;
    logic       pressed = 1'b0;
    int         press_col = 1;
    int         press_row = 2;
    logic       saw_valid;

    keypad_scan_decoder #(.N(4), .M(4), .DEBOUNCE(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .col_onehot   (col_onehot),
        .row_in       (row_in),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_code     (key_code),
        .key_down     (key_down),
        .overflow     (overflow),
        .col_err      (col_err),
        .clear_status (clear_status)
    );

    always #5 clk = ~clk;

    // One scan cycle: present the current ring column and its row returns, then advance.
    task automatic tick();
        col_onehot = ring;
        row_in = (pressed && ring == (4'b0001 << press_col)) ? (4'b0001 << press_row) : 4'b0000;
        @(posedge clk);
        #1;
        ring = {ring[2:0], ring[3]};
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align(input int c);
        for (int i = 0; i < 4; i++) begin
            if (ring != (4'b0001 << c)) tick();
        end
    endtask

    // A cycle with an illegal strobe; the ring does not advance.
    task automatic bad_tick(input logic [3:0] c, input logic [3:0] r);
        col_onehot = c;
        row_in = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick_n(2);
        reset = 1'b0;
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", key_code); end
        checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL reset_down got=%b exp=0", key_down); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        checks++; if (col_err !== 1'b0) begin failures++; $display("FAIL reset_colerr got=%b exp=0", col_err); end
    endtask

    task automatic test_clean_press();
        key_ready = 1'b0;
        press_col = 1; press_row = 2;
        align(1);
        pressed = 1'b1;
        tick();          // first visit; strobe entered column 1 one edge earlier
        tick_n(7);
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL clean_early got=%b exp=0", key_valid); end
        tick();          // third visit -> 9th edge since strobe entered column 1
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL clean_valid got=%b exp=1", key_valid); end
        checks++; if (key_code !== 4'd6) begin failures++; $display("FAIL clean_code got=%0d exp=6", key_code); end
        checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL clean_down got=%b exp=1", key_down); end
        key_ready = 1'b1;
        tick();
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL clean_accept got=%b exp=0", key_valid); end
        pressed = 1'b0;
        tick_n(16);
        checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL clean_release got=%b exp=0", key_down); end
        key_ready = 1'b0;
    endtask

    task automatic test_bounce();
        key_ready = 1'b0;
        press_col = 1; press_row = 2;
        align(1);
        pressed = 1'b1;
        tick();
        pressed = 1'b0;  // drops before the second visit
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (key_valid === 1'b1) saw_valid = 1'b1;
        end
        checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL bounce_noevent got=%b exp=0", saw_valid); end
        checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL bounce_down got=%b exp=0", key_down); end
        align(1);
        pressed = 1'b1;
        tick();
        tick_n(8);
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL bounce_repress got=%b exp=1", key_valid); end
        checks++; if (key_code !== 4'd6) begin failures++; $display("FAIL bounce_code got=%0d exp=6", key_code); end
        key_ready = 1'b1;
        tick();
        pressed = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (key_valid === 1'b1) saw_valid = 1'b1;
        end
        checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL bounce_single got=%b exp=0", saw_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bounce_ovf got=%b exp=0", overflow); end
        key_ready = 1'b0;
    endtask

    task automatic test_release_glitch();
        key_ready = 1'b1;
        press_col = 1; press_row = 2;
        align(1);
        pressed = 1'b1;
        tick();
        tick_n(8);
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL rel_valid got=%b exp=1", key_valid); end
        tick();
        saw_valid = 1'b0;
        pressed = 1'b0;
        align(1); tick();                 // release visit 1
        pressed = 1'b1;
        align(1); tick();                 // glitch at release visit 2
        pressed = 1'b0;
        if (key_valid === 1'b1) saw_valid = 1'b1;
        align(1); tick();
        align(1); tick();
        checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL rel_still_down got=%b exp=1", key_down); end
        if (key_valid === 1'b1) saw_valid = 1'b1;
        align(1); tick();
        checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL rel_down got=%b exp=0", key_down); end
        checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL rel_noevent got=%b exp=0", saw_valid); end
        key_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        key_ready = 1'b0;
        press_col = 1; press_row = 2;
        align(1); pressed = 1'b1; tick(); tick_n(8);
        checks++; if (key_code !== 4'd6) begin failures++; $display("FAIL bp_first_code got=%0d exp=6", key_code); end
        pressed = 1'b0; tick_n(12);
        press_col = 3; press_row = 1;
        align(3); pressed = 1'b1; tick(); tick_n(8);
        checks++; if (key_code !== 4'd6) begin failures++; $display("FAIL bp_code_stable got=%0d exp=6", key_code); end
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", key_valid); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_ovf got=%b exp=1", overflow); end
        checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL bp_down got=%b exp=1", key_down); end
        pressed = 1'b0; tick_n(12);
        clear_status = 1'b1; tick(); clear_status = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_clear got=%b exp=0", overflow); end
        align(3); pressed = 1'b1; tick(); tick_n(7);
        key_ready = 1'b1;
        tick();          // confirm and accept on the same edge
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL bp_nobubble got=%b exp=1", key_valid); end
        checks++; if (key_code !== 4'd13) begin failures++; $display("FAIL bp_newcode got=%0d exp=13", key_code); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_noovf got=%b exp=0", overflow); end
        tick();
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", key_valid); end
        pressed = 1'b0; tick_n(12);
        key_ready = 1'b0;
    endtask

    task automatic test_bad_strobe();
        key_ready = 1'b0;
        press_col = 1; press_row = 2;
        align(1); pressed = 1'b1; tick();
        bad_tick(4'b0000, 4'b0100);
        bad_tick(4'b0011, 4'b0100);
        checks++; if (col_err !== 1'b1) begin failures++; $display("FAIL bad_colerr got=%b exp=1", col_err); end
        tick_n(7);
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL bad_early got=%b exp=0", key_valid); end
        tick();
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL bad_delayed got=%b exp=1", key_valid); end
        checks++; if (key_code !== 4'd6) begin failures++; $display("FAIL bad_code got=%0d exp=6", key_code); end
        key_ready = 1'b1; tick(); key_ready = 1'b0;
        pressed = 1'b0; tick_n(12);
        checks++; if (col_err !== 1'b1) begin failures++; $display("FAIL bad_sticky got=%b exp=1", col_err); end
        clear_status = 1'b1; tick(); clear_status = 1'b0;
        checks++; if (col_err !== 1'b0) begin failures++; $display("FAIL bad_clear got=%b exp=0", col_err); end
    endtask

    task automatic test_reset_mid();
        key_ready = 1'b0;
        press_col = 1; press_row = 2;
        align(1); pressed = 1'b1; tick(); tick_n(4);   // two visits counted
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (key_down !== 1'b0 || key_valid !== 1'b0) begin failures++; $display("FAIL rst_mid got=%b%b exp=00", key_down, key_valid); end
        align(1); tick(); tick_n(7);
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_early got=%b exp=0", key_valid); end
        tick();
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_fresh got=%b exp=1", key_valid); end
        checks++; if (key_code !== 4'd6) begin failures++; $display("FAIL rst_mid_code got=%0d exp=6", key_code); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_pend_valid got=%b exp=0", key_valid); end
        checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL rst_pend_code got=%0d exp=0", key_code); end
        checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL rst_pend_down got=%b exp=0", key_down); end
        pressed = 1'b0; tick_n(12);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_backpressure();
        test_bad_strobe();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan_decoder.md
Name: keypad_scan_decoder

Overview:
- Consumes the one-hot column strobe from the synchronous ring counter, which drives keypad columns, together with the keypad row returns.
- Debounces presses and releases per key.
- Encodes the debounced key as a binary code.
- Delivers one event per press over a valid/ready handshake to the downstream controller, with sticky error/overflow status.

Parameters:
N, 4, number of columns; width of col_onehot, equal to the ring counter width
M, 4, number of rows
DEBOUNCE, 3, consecutive matching column visits required to confirm a press or a release (minimum 1)
CW, $clog2(N*M), key_code width (derived localparam, not overridable)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
col_onehot  input  N  current column strobe from the ring counter; advances one position per clk
row_in  input  M  row returns, active-high, already synchronized; valid for the column strobed in the same cycle
key_valid  output  1  key_code holds an unconsumed press event
key_ready  input  1  consumer accepts the event when key_valid && key_ready
key_code  output  CW  col_index*M + row_index of the confirmed key
key_down  output  1  debounced "a key is currently held" level
overflow  output  1  sticky; a confirmed press was dropped because the output was full
col_err  output  1  sticky; col_onehot was not exactly one-hot in some cycle
clear_status  input  1  clears overflow and col_err on the next edge

Behaviour:
- Reset, on the next clk edge with reset=1: state=IDLE, key_valid=0, key_code=0, key_down=0, overflow=0, col_err=0, debounce count=0. Reset overrides every other event, including one mid-debounce or during a pending handshake; a pending event is discarded.
- Column decode:
  - Each cycle, col_onehot is encoded to col_idx by a priority encoder (lowest set bit).
  - If popcount != 1, the cycle is ignored by the FSM, counters hold, and col_err is set.
- Row decode: row_idx = lowest set bit of row_in; hit = |row_in. Multiple rows: lowest index wins.
- State IDLE:
  - On a valid column with hit: latch cand_col=col_idx and cand_row=row_idx, count=1.
  - If DEBOUNCE==1, go to PRESS_CONFIRM behaviour in the same cycle; otherwise go to DEB_PRESS.
- State DEB_PRESS (evaluated only on cycles where col_idx==cand_col; other columns are ignored):
  - row_in[cand_row]==1: count++. When count reaches DEBOUNCE, confirm the press.
  - row_in[cand_row]==0: abort, return to IDLE, count=0.
- Confirm press:
  - key_down=1; state=HELD.
  - If key_valid==0, or a handshake completes in the same cycle: key_code={cand_col*M+cand_row}, key_valid=1.
  - Otherwise the event is dropped and overflow=1.
- State HELD, on cand_col visits:
  - row_in[cand_row]==0 starts or continues a release count.
  - Any visit with row_in[cand_row]==1 resets the release count.
  - When the release count reaches DEBOUNCE: key_down=0, state=IDLE.
  - Other keys are ignored while HELD; there is no rollover.
- Handshake:
  - key_valid falls on the edge where key_valid && key_ready.
  - key_code is stable while key_valid=1.
  - If a new confirm coincides with acceptance, the new event is loaded and key_valid stays 1 (no bubble, no overflow).
- Latency: a press stable from the first visit is reported (key_valid=1) on the edge after the DEBOUNCE-th visit to cand_col, i.e. (DEBOUNCE-1)*N+1 cycles after the first-visit edge.
- Status:
  - clear_status clears the sticky bits.
  - A set event in the same cycle wins over clear_status.
- Arithmetic: counters are $clog2(DEBOUNCE+1) bits, saturating; key_code is computed at CW width with no truncation.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state encoding: IDLE, DEB_PRESS, HELD (press confirm is a transition action, not a state).
  - The CW computation function.
- One natural sub-module: onehot_to_bin (parameterized width, lowest-set-bit priority encode plus a one-hot-valid flag). It is instantiated twice, for columns and rows.

Test Plan:
- Clean press, N=M=4, DEBOUNCE=3, row 2 held on column 1 (ring 0010): key_valid rises 9 cycles after first visit; key_code=6, key_down=1; ready=1 clears key_valid next edge.
- Bounce: row 2 on column 1 drops on the 2nd visit -> back to IDLE, no key_valid; re-press stable for 3 visits -> single event, code 6.
- Release debounce: hold then release with one glitch re-press at release visit 2 -> key_down stays 1 until 3 consecutive released visits, then 0; no second event.
- Backpressure: key_ready=0, press code 6, release, press code 13 (column 3, row 1) -> key_code stays 6, overflow=1. Pulse clear_status -> overflow=0. Press again with key_ready=1 on the confirm cycle -> new code loaded, key_valid stays high.
- Bad strobe: col_onehot=0000 for one cycle, then 0011 for one cycle -> col_err=1, debounce count unchanged, event timing delayed by exactly those ignored cycles.
- Reset mid-DEB_PRESS and with key_valid=1 pending -> next edge: all outputs 0; resumed stable press yields a fresh event after the full debounce.
